// File: rtl/registers_if.sv
// registers_if: bundles the core-side control, operand and status signals of the register file.
// Rev 1.0. write_count is present only when REGISTERS_WRITE_COUNT_EN is defined.
`default_nettype none

interface registers_if #(
    parameter int DATA_BITS = 8
);
    logic                 enable;
    logic [7:0]           block_id;
    logic [2:0]           core_state;
    logic [3:0]           decoded_rd_address;
    logic [3:0]           decoded_rs_address;
    logic [3:0]           decoded_rt_address;
    logic                 decoded_reg_write_enable;
    logic [1:0]           decoded_reg_input_mux;
    logic [DATA_BITS-1:0] decoded_immediate;
    logic [DATA_BITS-1:0] alu_out;
    logic [DATA_BITS-1:0] lsu_out;
    logic [DATA_BITS-1:0] rs;
    logic [DATA_BITS-1:0] rt;
    logic                 illegal_write;
`ifdef REGISTERS_WRITE_COUNT_EN
    logic [15:0]          write_count;
`endif

    modport master (
`ifdef REGISTERS_WRITE_COUNT_EN
        input  write_count,
`endif
        output enable, block_id, core_state,
        output decoded_rd_address, decoded_rs_address, decoded_rt_address,
        output decoded_reg_write_enable, decoded_reg_input_mux, decoded_immediate,
        output alu_out, lsu_out,
        input  rs, rt, illegal_write
    );

    modport slave (
`ifdef REGISTERS_WRITE_COUNT_EN
        output write_count,
`endif
        input  enable, block_id, core_state,
        input  decoded_rd_address, decoded_rs_address, decoded_rt_address,
        input  decoded_reg_write_enable, decoded_reg_input_mux, decoded_immediate,
        input  alu_out, lsu_out,
        output rs, rt, illegal_write
    );
endinterface

`default_nettype wire

// File: rtl/registers.sv
// registers: per-thread 16-entry register file (R13-R15 read-only block/thread ids), 1-cycle reads.
// Rev 1.0. Optional saturating write counter enabled by macro REGISTERS_WRITE_COUNT_EN.
`default_nettype none

module registers #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int THREAD_ID         = 0,
    parameter int DATA_BITS         = 8
) (
    input  wire logic    clk,
    input  wire logic    reset_n,
    registers_if.slave   bus
);
    localparam logic [2:0] c_REQUEST = 3'b011;
    localparam logic [2:0] c_UPDATE  = 3'b110;
    localparam logic [1:0] c_MUX_ALU = 2'b00;
    localparam logic [1:0] c_MUX_LSU = 2'b01;
    localparam logic [1:0] c_MUX_IMM = 2'b10;
    localparam logic [1:0] c_MUX_RSV = 2'b11;

    logic [DATA_BITS-1:0] regs_q [16];
    logic [DATA_BITS-1:0] regs_d [16];
    logic [DATA_BITS-1:0] rs_q, rs_d;
    logic [DATA_BITS-1:0] rt_q, rt_d;
    logic                 illegal_q, illegal_d;
    logic [DATA_BITS-1:0] blk_ext;
    logic [DATA_BITS-1:0] wb_data;
    logic                 wr_attempt;
    logic                 wr_commit;

    generate
        if (DATA_BITS > 8) begin : g_blk_wide
            assign blk_ext = {{(DATA_BITS-8){1'b0}}, bus.block_id};
        end else if (DATA_BITS == 8) begin : g_blk_exact
            assign blk_ext = bus.block_id;
        end else begin : g_blk_narrow
            assign blk_ext = bus.block_id[DATA_BITS-1:0];
        end
    endgenerate

    always_comb begin
        case (bus.decoded_reg_input_mux)
            c_MUX_LSU: wb_data = bus.lsu_out;
            c_MUX_IMM: wb_data = bus.decoded_immediate;
            default:   wb_data = bus.alu_out;
        endcase
    end

    // The reserved source neither writes nor counts as an illegal attempt.
    assign wr_attempt = bus.enable && (bus.core_state == c_UPDATE)
                        && bus.decoded_reg_write_enable
                        && (bus.decoded_reg_input_mux != c_MUX_RSV);
    assign wr_commit  = wr_attempt && (bus.decoded_rd_address < 4'd13);

    always_comb begin
        regs_d    = regs_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        illegal_d = illegal_q;
        if (bus.enable) begin
            regs_d[13] = blk_ext;
            if (bus.core_state == c_REQUEST) begin
                rs_d = regs_q[bus.decoded_rs_address];
                rt_d = regs_q[bus.decoded_rt_address];
            end
        end
        if (wr_commit) begin
            regs_d[bus.decoded_rd_address] = wb_data;
        end else if (wr_attempt) begin
            illegal_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 14; i++) begin
                regs_q[i] <= '0;
            end
            regs_q[14] <= DATA_BITS'(THREADS_PER_BLOCK);
            regs_q[15] <= DATA_BITS'(THREAD_ID);
            rs_q       <= '0;
            rt_q       <= '0;
            illegal_q  <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.rs            = rs_q;
    assign bus.rt            = rt_q;
    assign bus.illegal_write = illegal_q;

`ifdef REGISTERS_WRITE_COUNT_EN
    logic [15:0] wcount_q, wcount_d;

    always_comb begin
        wcount_d = wcount_q;
        if (wr_commit && (wcount_q != 16'hFFFF)) begin
            wcount_d = wcount_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wcount_q <= '0;
        end else begin
            wcount_q <= wcount_d;
        end
    end

    assign bus.write_count = wcount_q;
`endif

    // Kept only so every mux code has a named meaning alongside the case above.
    logic unused_ok;
    assign unused_ok = &{1'b0, c_MUX_ALU};

endmodule

`default_nettype wire

// File: tb/tb_registers.sv
// tb_registers: directed self-checking bench for registers (THREAD_ID=2, THREADS_PER_BLOCK=4).
// Rev 1.0. Counter checks are compiled in when REGISTERS_WRITE_COUNT_EN is defined.
`default_nettype none

module tb_registers;
    localparam logic [2:0] c_IDLE    = 3'b000;
    localparam logic [2:0] c_REQUEST = 3'b011;
    localparam logic [2:0] c_UPDATE  = 3'b110;

    logic clk     = 1'b0;
    logic clk_run = 1'b0;
    logic reset_n = 1'b1;
    int   n_cmp   = 0;
    int   n_fail  = 0;

    registers_if #(.DATA_BITS(8)) bus ();

    registers #(
        .THREADS_PER_BLOCK(4),
        .THREAD_ID        (2),
        .DATA_BITS        (8)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 if (clk_run) clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] st, input logic [3:0] rd, input logic [3:0] ra,
                         input logic [3:0] rb, input logic we, input logic [1:0] mux);
        bus.core_state               = st;
        bus.decoded_rd_address       = rd;
        bus.decoded_rs_address       = ra;
        bus.decoded_rt_address       = rb;
        bus.decoded_reg_write_enable = we;
        bus.decoded_reg_input_mux    = mux;
    endtask

    initial begin
        bus.enable            = 1'b1;
        bus.block_id          = 8'd0;
        bus.decoded_immediate = 8'h00;
        bus.alu_out           = 8'h00;
        bus.lsu_out           = 8'h00;
        drive(c_IDLE, 4'd0, 4'd0, 4'd0, 1'b0, 2'b00);

        // Reset with the clock stopped: outputs must clear asynchronously.
        #2 reset_n = 1'b0;
        #1;
        chk("reset_rs", 16'(bus.rs), 16'h0);
        chk("reset_rt", 16'(bus.rt), 16'h0);
        chk("reset_illegal", 16'(bus.illegal_write), 16'h0);
`ifdef REGISTERS_WRITE_COUNT_EN
        chk("reset_count", bus.write_count, 16'h0);
`endif
        #3 reset_n = 1'b1;
        #2 clk_run = 1'b1;

        drive(c_REQUEST, 4'd0, 4'd14, 4'd15, 1'b0, 2'b00);
        tick();
        chk("r14_block_size", 16'(bus.rs), 16'h4);
        chk("r15_thread_id", 16'(bus.rt), 16'h2);

        // Reserved source targeting a read-only register: no write, no flag.
        bus.decoded_immediate = 8'h77;
        drive(c_UPDATE, 4'd14, 4'd0, 4'd0, 1'b1, 2'b11);
        tick();
        chk("rsv_no_illegal", 16'(bus.illegal_write), 16'h0);
        drive(c_UPDATE, 4'd5, 4'd0, 4'd0, 1'b1, 2'b11);
        tick();
        drive(c_REQUEST, 4'd0, 4'd5, 4'd14, 1'b0, 2'b00);
        tick();
        chk("rsv_no_write_r5", 16'(bus.rs), 16'h0);
        chk("rsv_r14_kept", 16'(bus.rt), 16'h4);

        bus.decoded_immediate = 8'h2A;
        drive(c_UPDATE, 4'd3, 4'd0, 4'd0, 1'b1, 2'b10);
        tick();
        drive(c_REQUEST, 4'd0, 4'd3, 4'd0, 1'b0, 2'b00);
        tick();
        chk("wb_imm_r3", 16'(bus.rs), 16'h2A);

        bus.alu_out = 8'h11;
        drive(c_UPDATE, 4'd3, 4'd0, 4'd0, 1'b1, 2'b00);
        tick();
        chk("update_holds_rs", 16'(bus.rs), 16'h2A);
        drive(c_REQUEST, 4'd0, 4'd3, 4'd0, 1'b0, 2'b00);
        tick();
        chk("wb_alu_r3", 16'(bus.rs), 16'h11);

        bus.lsu_out = 8'h55;
        drive(c_UPDATE, 4'd15, 4'd0, 4'd0, 1'b1, 2'b01);
        tick();
        chk("ro_sets_illegal", 16'(bus.illegal_write), 16'h1);
        drive(c_UPDATE, 4'd4, 4'd0, 4'd0, 1'b1, 2'b01);
        tick();
        drive(c_REQUEST, 4'd0, 4'd4, 4'd15, 1'b0, 2'b00);
        tick();
        chk("wb_lsu_r4", 16'(bus.rs), 16'h55);
        chk("ro_r15_kept", 16'(bus.rt), 16'h2);
        chk("illegal_sticky", 16'(bus.illegal_write), 16'h1);
`ifdef REGISTERS_WRITE_COUNT_EN
        chk("count_three", bus.write_count, 16'h3);
`endif

        // Disabled thread: nothing moves, block_id is not sampled.
        bus.enable   = 1'b0;
        bus.block_id = 8'd9;
        drive(c_REQUEST, 4'd0, 4'd3, 4'd14, 1'b0, 2'b00);
        tick();
        chk("dis_rs_hold", 16'(bus.rs), 16'h55);
        chk("dis_rt_hold", 16'(bus.rt), 16'h2);
        bus.decoded_immediate = 8'h07;
        drive(c_UPDATE, 4'd1, 4'd0, 4'd0, 1'b1, 2'b10);
        tick();
`ifdef REGISTERS_WRITE_COUNT_EN
        chk("dis_count_hold", bus.write_count, 16'h3);
`endif
        bus.enable = 1'b1;
        drive(c_REQUEST, 4'd0, 4'd1, 4'd13, 1'b0, 2'b00);
        tick();
        chk("dis_r1_unwritten", 16'(bus.rs), 16'h0);
        chk("r13_old_on_reload", 16'(bus.rt), 16'h0);
        tick();
        chk("r13_block_id", 16'(bus.rt), 16'h9);

        // Reset landing mid-UPDATE discards the write.
        bus.decoded_immediate = 8'h33;
        drive(c_UPDATE, 4'd2, 4'd0, 4'd0, 1'b1, 2'b10);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_clears_illegal", 16'(bus.illegal_write), 16'h0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(c_REQUEST, 4'd0, 4'd2, 4'd13, 1'b0, 2'b00);
        tick();
        chk("rst_abort_r2", 16'(bus.rs), 16'h0);
        chk("rst_r13_zero", 16'(bus.rt), 16'h0);

`ifdef REGISTERS_WRITE_COUNT_EN
        chk("rst_count_zero", bus.write_count, 16'h0);
        bus.decoded_immediate = 8'h01;
        drive(c_UPDATE, 4'd0, 4'd0, 4'd0, 1'b1, 2'b10);
        for (int i = 0; i < 65535; i++) begin
            @(posedge clk);
        end
        #1;
        chk("count_full", bus.write_count, 16'hFFFF);
        tick();
        chk("count_saturate", bus.write_count, 16'hFFFF);
`endif

        drive(c_IDLE, 4'd0, 4'd0, 4'd0, 1'b0, 2'b00);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
